// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer over a shared ALU and single memory.
// State is registered; all control outputs are decoded combinationally from state, IR fields, z and mem_rdy.
module mc_cu #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic       inst_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t cur, nxt;
  logic   rdy;

  assign rdy   = mem_rdy | ~MEM_WAIT_EN;
  assign state = cur;

  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic r_alu, i_alu, legal;

  assign r_type = (op == 6'h00);
  assign i_add  = r_type & (func == 6'h20);
  assign i_sub  = r_type & (func == 6'h22);
  assign i_and  = r_type & (func == 6'h24);
  assign i_or   = r_type & (func == 6'h25);
  assign i_xor  = r_type & (func == 6'h26);
  assign i_sll  = r_type & (func == 6'h00);
  assign i_srl  = r_type & (func == 6'h02);
  assign i_sra  = r_type & (func == 6'h03);
  assign i_jr   = r_type & (func == 6'h08);
  assign i_addi = (op == 6'h08);
  assign i_andi = (op == 6'h0c);
  assign i_ori  = (op == 6'h0d);
  assign i_xori = (op == 6'h0e);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2b);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_lui  = (op == 6'h0f);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);

  assign r_alu = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra;
  assign i_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign legal = r_alu | i_jr | i_alu | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

  // Logical immediates zero-extend; everything else (including branch offsets) sign-extends.
  assign sext = ~(i_andi | i_ori | i_xori);

  logic [3:0] aluc_r, aluc_i;

  always_comb begin
    aluc_r = 4'b0000;
    if (i_sub) aluc_r = 4'b0100;
    if (i_and) aluc_r = 4'b0001;
    if (i_or)  aluc_r = 4'b0101;
    if (i_xor) aluc_r = 4'b0010;
    if (i_sll) aluc_r = 4'b0011;
    if (i_srl) aluc_r = 4'b0111;
    if (i_sra) aluc_r = 4'b1111;
    aluc_i = 4'b0000;
    if (i_andi) aluc_i = 4'b0001;
    if (i_ori)  aluc_i = 4'b0101;
    if (i_xori) aluc_i = 4'b0010;
    if (i_lui)  aluc_i = 4'b0110;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= S_IF;
    else       cur <= nxt;
  end

  always_comb begin
    nxt       = S_IF;
    wpc       = 1'b0;
    wir       = 1'b0;
    wmem      = 1'b0;
    wreg      = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    jal       = 1'b0;
    shift     = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluc      = 4'b0000;
    pcsource  = 2'b00;
    illegal   = 1'b0;
    inst_done = 1'b0;
    case (cur)
      S_IF: begin
        alusrcb = 2'b01;
        wir     = rdy;
        wpc     = rdy;
        nxt     = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        alusrcb = 2'b11;
        if (i_j | i_jal) begin
          wpc       = 1'b1;
          pcsource  = 2'b11;
          wreg      = i_jal;
          jal       = i_jal;
          inst_done = 1'b1;
        end else if (i_jr) begin
          wpc       = 1'b1;
          pcsource  = 2'b10;
          inst_done = 1'b1;
        end else if (!legal) begin
          illegal   = 1'b1;
          inst_done = 1'b1;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        if (i_beq | i_bne) begin
          aluc      = 4'b0100;
          wpc       = (i_beq & z) | (i_bne & ~z);
          pcsource  = 2'b01;
          inst_done = 1'b1;
        end else if (r_type) begin
          aluc  = aluc_r;
          shift = i_sll | i_srl | i_sra;
          nxt   = S_WB;
        end else begin
          alusrcb = 2'b10;
          aluc    = aluc_i;
          nxt     = (i_lw | i_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        // wmem stays asserted until the memory accepts the store.
        iord = 1'b1;
        wmem = i_sw;
        if (!rdy)      nxt = S_MEM;
        else if (i_sw) inst_done = 1'b1;
        else           nxt = S_WB;
      end
      S_WB: begin
        wreg      = 1'b1;
        regrt     = ~r_type;
        m2reg     = i_lw;
        inst_done = 1'b1;
      end
      default: nxt = S_IF;
    endcase
    if (reset) begin
      wpc       = 1'b0;
      wir       = 1'b0;
      wmem      = 1'b0;
      wreg      = 1'b0;
      illegal   = 1'b0;
      inst_done = 1'b0;
    end
  end

endmodule
